// File: rtl/approx_mult_seq.sv
// Sequential WIDTHxWIDTH multiplier: one HxH partial product per cycle, exact (add) or approximate (OR) accumulation.
// Optional per-mode completion counters when APPROX_MULT_PERF_CNT_EN is defined.
module approx_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_precise,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_y,
  output logic               out_precise
`ifdef APPROX_MULT_PERF_CNT_EN
  ,
  output logic [31:0]        cnt_precise,
  output logic [31:0]        cnt_approx
`endif
);

  localparam int H = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               prec_q, prec_d;
  logic               accept;

  // Shared HxH multiplier; idx[1] picks the a half, idx[0] the b half.
  logic [H-1:0]       op_a, op_b;
  logic [2*H-1:0]     pp;
  logic [2*WIDTH-1:0] pp_ext, pp_sh;

  assign op_a   = idx_q[1] ? a_q[WIDTH-1:H] : a_q[H-1:0];
  assign op_b   = idx_q[0] ? b_q[WIDTH-1:H] : b_q[H-1:0];
  assign pp     = {{H{1'b0}}, op_a} * {{H{1'b0}}, op_b};
  assign pp_ext = {{WIDTH{1'b0}}, pp};

  always_comb begin
    pp_sh = pp_ext;
    case (idx_q)
      2'd0:    pp_sh = pp_ext;
      2'd1,
      2'd2:    pp_sh = pp_ext << H;
      default: pp_sh = pp_ext << (2 * H);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    prec_d    = prec_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      MUL: begin
        acc_d = prec_q ? (acc_q + pp_sh) : (acc_q | pp_sh);
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Retiring and accepting share one edge so back-to-back ops take 5 cycles.
        in_ready  = out_ready;
        if (out_ready) begin
          state_d = IDLE;
          accept  = in_valid;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      a_d     = in_a;
      b_d     = in_b;
      prec_d  = in_precise;
      acc_d   = '0;
      idx_d   = 2'd0;
      state_d = MUL;
    end
  end

  assign out_y       = out_valid ? acc_q : '0;
  assign out_precise = out_valid & prec_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prec_q  <= prec_d;
    end
  end

`ifdef APPROX_MULT_PERF_CNT_EN
  logic [31:0] cnt_precise_q, cnt_precise_d, cnt_approx_q, cnt_approx_d;

  always_comb begin
    cnt_precise_d = cnt_precise_q;
    cnt_approx_d  = cnt_approx_q;
    if (out_valid && out_ready) begin
      if (prec_q && cnt_precise_q != 32'hFFFF_FFFF) cnt_precise_d = cnt_precise_q + 32'd1;
      if (!prec_q && cnt_approx_q != 32'hFFFF_FFFF) cnt_approx_d = cnt_approx_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_precise_q <= '0;
      cnt_approx_q  <= '0;
    end else begin
      cnt_precise_q <= cnt_precise_d;
      cnt_approx_q  <= cnt_approx_d;
    end
  end

  assign cnt_precise = cnt_precise_q;
  assign cnt_approx  = cnt_approx_q;
`endif

endmodule

// File: tb/tb_approx_mult_seq.sv
// Self-checking bench for approx_mult_seq (WIDTH=16): vector table, handshake corners, random ops vs. reference model.
module tb_approx_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_precise;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready, out_precise;
  logic [31:0] out_y;
`ifdef APPROX_MULT_PERF_CNT_EN
  logic [31:0] cnt_precise, cnt_approx;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  approx_mult_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_precise(in_precise),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_precise(out_precise)
`ifdef APPROX_MULT_PERF_CNT_EN
    , .cnt_precise(cnt_precise), .cnt_approx(cnt_approx)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          p;
    logic [31:0] y;
  } vec_t;

  // Reference: exact product, or OR of the four byte-level partial products.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input bit p);
    int unsigned al = a % 256, ah = a / 256, bl = b % 256, bh = b / 256;
    logic [31:0] p0 = 32'(al * bl);
    logic [31:0] p1 = 32'(al * bh) * 256;
    logic [31:0] p2 = 32'(ah * bl) * 256;
    logic [31:0] p3 = 32'(ah * bh) * 65536;
    if (p) return 32'(a) * 32'(b);
    return p0 | p1 | p2 | p3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid, returning edges elapsed; in_ready must stay low while busy.
  task automatic wait_res(output int n);
    bit busy_bad = 0;
    n = 0;
    while (!out_valid && n < 16) begin
      if (in_ready !== 1'b0) busy_bad = 1;
      tick();
      n++;
    end
    chk("busy_in_ready_low", busy_bad, 0);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit p,
                       input int stall, input logic [31:0] exp_y);
    int n;
    logic [31:0] held;
    chk("accept_ready", in_ready, 1);
    in_a = a; in_b = b; in_precise = p; in_valid = 1;
    tick();
    in_valid = 0;
    in_a = 16'($urandom); in_b = 16'($urandom); in_precise = 1'($urandom);
    wait_res(n);
    chk("latency", n, 4);
    held = out_y;
    repeat (stall) begin
      in_a = 16'($urandom);
      tick();
    end
    chk("out_y", out_y, exp_y);
    chk("out_y_hold", out_y, held);
    chk("out_precise", out_precise, p);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("retire_to_idle", {out_valid, in_ready}, 2'b01);
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    bit seen;
    logic [15:0] ra, rb;
    bit rp;

    vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFEFFFF01};
    vecs[2] = '{16'h0102, 16'h0304, 1'b1, 32'h00030A08};
    vecs[3] = '{16'h0102, 16'h0304, 1'b0, 32'h00030608};
    vecs[4] = '{16'h0000, 16'hFFFF, 1'b1, 32'h00000000};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 32'h40000000};
    vecs[6] = '{16'h0001, 16'h0001, 1'b0, 32'h00000001};
    vecs[7] = '{16'h00FF, 16'hFF00, 1'b1, 32'h00FE0100};

    rst_n = 0; in_valid = 0; out_ready = 0; in_a = 0; in_b = 0; in_precise = 0;
    tick(); tick();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_y", out_y, 0);
    chk("reset_out_precise", out_precise, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1;
    tick();

    for (int i = 0; i < 8; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].p, i % 3, vecs[i].y);

    // Long stall in DONE, then retire and accept on the same edge.
    in_a = 16'h1234; in_b = 16'h5678; in_precise = 1; in_valid = 1;
    tick();
    in_valid = 0;
    wait_res(n);
    chk("stall_latency", n, 4);
    for (int i = 0; i < 10; i++) begin
      in_a = 16'($urandom);
      tick();
      chk("stall_hold", {out_valid, in_ready, out_y}, {2'b10, model(16'h1234, 16'h5678, 1)});
    end
    out_ready = 1; in_valid = 1; in_a = 16'h0102; in_b = 16'h0304; in_precise = 0;
    tick();
    out_ready = 0; in_valid = 0; in_a = 16'hFFFF;
    chk("b2b_busy", {out_valid, in_ready}, 2'b00);
    wait_res(n);
    chk("b2b_latency", n, 4);
    chk("b2b_out_y", out_y, 32'h00030608);
    chk("b2b_precise", out_precise, 0);
    out_ready = 1;
    tick();
    out_ready = 0;

    // Reset mid-multiply (idx=2), with in_valid high at the reset edge.
    in_a = 16'hABCD; in_b = 16'h1357; in_precise = 1; in_valid = 1;
    tick();
    in_valid = 0;
    tick(); tick();
    rst_n = 0; in_valid = 1;
    tick();
    rst_n = 1; in_valid = 0;
    chk("abort_state", {out_valid, in_ready, out_y}, {2'b01, 32'h0});
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    chk("abort_no_result", seen, 0);

    // Reset while stalled in DONE.
    in_a = 16'h00FF; in_b = 16'h00FF; in_precise = 0; in_valid = 1;
    tick();
    in_valid = 0;
    wait_res(n);
    out_ready = 1; rst_n = 0;
    tick();
    rst_n = 1; out_ready = 0;
    chk("done_abort", {out_valid, in_ready, out_precise, out_y}, {3'b010, 32'h0});

    for (int i = 0; i < 120; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rp = 1'($urandom);
      if (i % 10 == 0) ra = 16'hFFFF;
      do_op(ra, rb, rp, int'($urandom_range(0, 3)), model(ra, rb, rp));
    end

`ifdef APPROX_MULT_PERF_CNT_EN
    do_reset();
    chk("cnt_reset", {cnt_precise, cnt_approx}, 64'h0);
    for (int i = 0; i < 5; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rp = (i < 3);
      do_op(ra, rb, rp, 0, model(ra, rb, rp));
    end
    chk("cnt_precise", cnt_precise, 3);
    chk("cnt_approx", cnt_approx, 2);
    in_a = 16'h0003; in_b = 16'h0005; in_precise = 1; in_valid = 1;
    tick();
    in_valid = 0;
    wait_res(n);
    repeat (3) tick();
    chk("cnt_stalled", cnt_precise, 3);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("cnt_after_retire", {cnt_precise, cnt_approx}, {32'd4, 32'd2});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_mult_seq.md
APPROX_MULT_SEQ -- requirements
Module: approx_mult_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be even and >= 4; H = WIDTH/2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 in_a  input  WIDTH  multiplicand.
REQ-007 in_b  input  WIDTH  multiplier.
REQ-008 in_precise  input  1  1 = exact product, 0 = approximate product.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_y  output  2*WIDTH  product.
REQ-012 out_precise  output  1  mode under which out_y was computed.

Function
REQ-013 Split operands: aL=in_a[H-1:0], aH=in_a[WIDTH-1:H], bL and bH likewise; one shared HxH exact multiplier, one partial product per cycle.
REQ-014 Partial-product order: P0=aL*bL shift 0; P1=aL*bH shift H; P2=aH*bL shift H; P3=aH*bH shift 2H; each 2H bits, zero-extended to 2*WIDTH before shifting.
REQ-015 Precise mode: acc = acc + shifted Pi, full 2*WIDTH carry propagation; final acc = in_a*in_b exactly.
REQ-016 Approximate mode: acc = acc | shifted Pi, no carries; result bits [H-1:0] = P0 low half only; overlapping columns are ORed.
REQ-017 FSM states IDLE, MUL, DONE; 2-bit index idx inside MUL.
REQ-018 IDLE: in_ready=1; on in_valid at a clock edge -> latch in_a, in_b, in_precise; acc=0; idx=0; enter MUL.
REQ-019 MUL: in_ready=0; each edge accumulates P[idx] and increments idx; after the edge that processes idx=3, enter DONE.
REQ-020 Latency: out_valid SHALL rise exactly 4 edges after the accepting edge; sustained throughput 1 result / 5 cycles without overlap.
REQ-021 DONE: out_valid=1; out_y=acc; out_precise=latched mode; out_y and out_precise SHALL stay stable while out_ready=0.
REQ-022 DONE with out_ready=1: result retired at that edge; in_ready=out_ready in DONE, so a simultaneous in_valid is accepted at the same edge and the next state is MUL idx=0; otherwise the next state is IDLE.
REQ-023 in_a, in_b, in_precise changes after acceptance SHALL have no effect on the operation in flight.
REQ-024 out_valid SHALL be 0 in IDLE and MUL.

Reset
REQ-025 rst_n=0 at an edge: state=IDLE, idx=0, acc=0, latched operands and mode=0; out_valid=0, out_y=0, out_precise=0; in_ready=1 from the first cycle after reset.
REQ-026 Reset during MUL or DONE SHALL discard the operation; no result is emitted for it.
REQ-027 rst_n has priority over every handshake sampled at the same edge.

Configuration
REQ-028 Macro APPROX_MULT_PERF_CNT_EN defined: add outputs cnt_precise and cnt_approx, each 32 bits and reset to 0; the counter matching out_precise SHALL increment on each out_valid & out_ready edge and saturate at 0xFFFFFFFF.
REQ-029 Macro not defined: the counters and their ports SHALL be absent; all other behaviour is identical.

Verification (WIDTH=16)
REQ-030 a=0xFFFF, b=0xFFFF, precise=1 -> out_y=0xFFFE0001, out_precise=1, out_valid 4 edges after acceptance.
REQ-031 a=0xFFFF, b=0xFFFF, precise=0 -> out_y=0xFEFFFF01, out_precise=0.
REQ-032 a=0x0102, b=0x0304: precise=1 -> 0x00030A08; precise=0 -> 0x00030608.
REQ-033 Hold out_ready=0 for 10 cycles in DONE while toggling in_a -> out_y stable, in_ready=0; then out_ready=1 with in_valid=1 -> result retired and new operands accepted at the same edge.
REQ-034 Assert rst_n=0 at idx=2 -> next cycle out_valid=0, out_y=0, in_ready=1; no result for the aborted operation ever appears.
REQ-035 With APPROX_MULT_PERF_CNT_EN: 3 precise + 2 approximate completed ops -> cnt_precise=3, cnt_approx=2; a result stalled in DONE is not counted until its handshake.
